// File: rtl/debug_mem_sequencer_if.sv
// Signal bundle between the debug command decoder / memory bus mux and the
// debug memory sequencer. The master side drives requests; the slave sequences them.
interface debug_mem_sequencer_if;
    logic       COMMIT;
    logic       DEBUG_REQ;
    logic       DEBUG_WR;
    logic       DEBUG_AUTO_INC;
    logic [7:0] DEBUG_COUNT;
    logic       DEBUG_XFER_READY;
    logic       DEBUG_ABORT;
    logic       CPU_HOLD;
    logic       MEM_RD;
    logic       MEM_WR;
    logic       DEBUG_DATA_LD;
    logic       DEBUG_ADDR_INC;
    logic       DEBUG_DONE;
    logic       BUSY;
    logic [8:0] DEBUG_REMAIN;

    modport master (
        output COMMIT, DEBUG_REQ, DEBUG_WR, DEBUG_AUTO_INC, DEBUG_COUNT,
               DEBUG_XFER_READY, DEBUG_ABORT,
        input  CPU_HOLD, MEM_RD, MEM_WR, DEBUG_DATA_LD, DEBUG_ADDR_INC,
               DEBUG_DONE, BUSY, DEBUG_REMAIN
    );

    modport slave (
        input  COMMIT, DEBUG_REQ, DEBUG_WR, DEBUG_AUTO_INC, DEBUG_COUNT,
               DEBUG_XFER_READY, DEBUG_ABORT,
        output CPU_HOLD, MEM_RD, MEM_WR, DEBUG_DATA_LD, DEBUG_ADDR_INC,
               DEBUG_DONE, BUSY, DEBUG_REMAIN
    );
endinterface

// File: rtl/debug_mem_sequencer.sv
// Runs 1-256 word debug memory bursts at instruction boundaries: waits for
// COMMIT, holds the CPU off the bus, and paces each word on DEBUG_XFER_READY.
module debug_mem_sequencer (
    input  logic                 CLK,
    input  logic                 RESET,
    debug_mem_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_COMMIT,
        HOLD,
        WAIT_RDY,
        ACCESS,
        LATCH,
        RELEASE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       wr_q;
    logic       auto_inc_q;
    logic [8:0] remain_q;

    // A count of zero encodes a full 256-word burst.
    function automatic logic [8:0] count_to_words(input logic [7:0] count);
        return (count == 8'd0) ? 9'd256 : {1'b0, count};
    endfunction

    function automatic logic [8:0] sat_dec(input logic [8:0] value);
        return (value == 9'd0) ? 9'd0 : value - 9'd1;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            remain_q <= 9'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.DEBUG_REQ)
                remain_q <= count_to_words(bus.DEBUG_COUNT);
            else if (state == LATCH)
                remain_q <= sat_dec(remain_q);
        end
    end

    // Direction and auto-increment only matter once a burst is under way.
    always_ff @(posedge CLK) begin
        if (state == IDLE && bus.DEBUG_REQ) begin
            wr_q       <= bus.DEBUG_WR;
            auto_inc_q <= bus.DEBUG_AUTO_INC;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (bus.DEBUG_REQ) state_next = WAIT_COMMIT;
            WAIT_COMMIT: begin
                if (bus.DEBUG_ABORT)
                    state_next = RELEASE;
                else if (bus.COMMIT)
                    state_next = HOLD;
            end
            HOLD:        state_next = WAIT_RDY;
            WAIT_RDY: begin
                if (bus.DEBUG_ABORT)
                    state_next = RELEASE;
                else if (bus.DEBUG_XFER_READY)
                    state_next = ACCESS;
            end
            ACCESS:      state_next = LATCH;
            LATCH: begin
                if (remain_q <= 9'd1 || bus.DEBUG_ABORT)
                    state_next = RELEASE;
                else
                    state_next = WAIT_RDY;
            end
            RELEASE:     state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.CPU_HOLD       = 1'b0;
        bus.MEM_RD         = 1'b0;
        bus.MEM_WR         = 1'b0;
        bus.DEBUG_DATA_LD  = 1'b0;
        bus.DEBUG_ADDR_INC = 1'b0;
        bus.DEBUG_DONE     = 1'b0;
        bus.BUSY           = (state != IDLE);
        case (state)
            HOLD, WAIT_RDY: bus.CPU_HOLD = 1'b1;
            ACCESS: begin
                bus.CPU_HOLD = 1'b1;
                bus.MEM_WR   = wr_q;
                bus.MEM_RD   = ~wr_q;
            end
            LATCH: begin
                bus.CPU_HOLD       = 1'b1;
                bus.DEBUG_DATA_LD  = ~wr_q;
                bus.DEBUG_ADDR_INC = auto_inc_q;
            end
            RELEASE: bus.DEBUG_DONE = 1'b1;
            default: ;
        endcase
    end

    assign bus.DEBUG_REMAIN = remain_q;

endmodule

// File: tb/tb_debug_mem_sequencer.sv
// Scoreboard bench for debug_mem_sequencer: stimulus queues expected strobe
// events and CPU_HOLD run lengths; a negedge monitor pops and compares them.
module tb_debug_mem_sequencer;

    logic CLK = 1'b0;
    logic RESET;
    debug_mem_sequencer_if bus ();

    debug_mem_sequencer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         kind;      // 0 = strobe event, 1 = CPU_HOLD falling (run length)
        logic [4:0] strb;      // {MEM_RD, MEM_WR, DATA_LD, ADDR_INC, DONE}
        int         remain;
        int         delta;     // cycles since previous event, -1 = don't care
        int         hold;
    } exp_t;

    localparam logic [4:0] S_RD   = 5'b10000;
    localparam logic [4:0] S_WR   = 5'b01000;
    localparam logic [4:0] S_LD   = 5'b00100;
    localparam logic [4:0] S_INC  = 5'b00010;
    localparam logic [4:0] S_DONE = 5'b00001;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   last_evt    = 0;
    int   hold_len    = 0;
    logic hold_prev   = 1'b0;
    logic [4:0] strb_obs;

    always @(posedge CLK) cyc++;

    task automatic push_evt(input logic [4:0] strb, input int remain, input int delta);
        exp_t e;
        e.kind = 0; e.strb = strb; e.remain = remain; e.delta = delta; e.hold = 0;
        sb.push_back(e);
    endtask

    task automatic push_hold(input int len);
        exp_t e;
        e.kind = 1; e.strb = 5'b0; e.remain = 0; e.delta = -1; e.hold = len;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every observed strobe cycle and every CPU_HOLD run.
    always @(negedge CLK) begin
        exp_t e;
        if (hold_prev && bus.CPU_HOLD !== 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL hold_run: unexpected run of %0d cycles", hold_len);
            end else begin
                e = sb.pop_front();
                if (e.kind != 1 || e.hold != hold_len) begin
                    miscompares++;
                    $display("FAIL hold_run: got run %0d, expected kind %0d run %0d strb %b",
                             hold_len, e.kind, e.hold, e.strb);
                end
            end
        end
        hold_len  = (bus.CPU_HOLD === 1'b1) ? hold_len + 1 : 0;
        hold_prev = (bus.CPU_HOLD === 1'b1);
        strb_obs  = {bus.MEM_RD, bus.MEM_WR, bus.DEBUG_DATA_LD, bus.DEBUG_ADDR_INC, bus.DEBUG_DONE};
        if (strb_obs != 5'b0) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL strobe: unexpected strb %b remain %0d", strb_obs, bus.DEBUG_REMAIN);
            end else begin
                e = sb.pop_front();
                if (e.kind != 0 || e.strb !== strb_obs || e.remain != int'(bus.DEBUG_REMAIN) ||
                    (e.delta >= 0 && e.delta != cyc - last_evt)) begin
                    miscompares++;
                    $display("FAIL strobe: got strb %b remain %0d delta %0d, expected kind %0d strb %b remain %0d delta %0d",
                             strb_obs, bus.DEBUG_REMAIN, cyc - last_evt, e.kind, e.strb, e.remain, e.delta);
                end
            end
            last_evt = cyc;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_req(input logic [7:0] count, input logic wr, input logic auto_inc);
        bus.DEBUG_REQ      = 1'b1;
        bus.DEBUG_COUNT    = count;
        bus.DEBUG_WR       = wr;
        bus.DEBUG_AUTO_INC = auto_inc;
        tick();
        bus.DEBUG_REQ      = 1'b0;
        bus.DEBUG_COUNT    = 8'hA5;
        bus.DEBUG_WR       = ~wr;
        bus.DEBUG_AUTO_INC = ~auto_inc;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && bus.BUSY !== 1'b0; i++) tick();
        chk(name, bus.BUSY, 1'b0);
    endtask

    function automatic logic [6:0] all_outs();
        return {bus.CPU_HOLD, bus.MEM_RD, bus.MEM_WR, bus.DEBUG_DATA_LD,
                bus.DEBUG_ADDR_INC, bus.DEBUG_DONE, bus.BUSY};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET                = 1'b1;
        bus.COMMIT           = 1'b0;
        bus.DEBUG_REQ        = 1'b1;
        bus.DEBUG_WR         = 1'b0;
        bus.DEBUG_AUTO_INC   = 1'b0;
        bus.DEBUG_COUNT      = 8'd2;
        bus.DEBUG_XFER_READY = 1'b0;
        bus.DEBUG_ABORT      = 1'b0;

        // Reset with REQ high and COMMIT toggling
        tick();
        chk("rst1_outs", all_outs(), 7'd0);
        chk("rst1_remain", bus.DEBUG_REMAIN, 9'd0);
        bus.COMMIT = 1'b1;
        tick();
        chk("rst2_outs", all_outs(), 7'd0);
        chk("rst2_remain", bus.DEBUG_REMAIN, 9'd0);
        RESET = 1'b0;
        bus.COMMIT = 1'b0;
        tick();
        chk("post_rst_busy", bus.BUSY, 1'b1);
        chk("post_rst_remain", bus.DEBUG_REMAIN, 9'd2);
        bus.DEBUG_REQ = 1'b0;
        push_evt(S_DONE, 2, -1);
        bus.DEBUG_ABORT = 1'b1;
        tick();
        chk("rst_abort_done", bus.DEBUG_DONE, 1'b1);
        bus.DEBUG_ABORT = 1'b0;
        tick();
        chk("rst_abort_idle", bus.BUSY, 1'b0);

        // Single read with auto-increment
        bus.DEBUG_XFER_READY = 1'b1;
        bus.COMMIT = 1'b1;
        tick();
        bus.COMMIT = 1'b0;
        start_req(8'd1, 1'b0, 1'b1);
        chk("rd1_busy", bus.BUSY, 1'b1);
        chk("rd1_remain", bus.DEBUG_REMAIN, 9'd1);
        push_evt(S_RD, 1, -1);
        push_evt(S_LD | S_INC, 1, 1);
        push_hold(4);
        push_evt(S_DONE, 0, 1);
        repeat (2) tick();
        chk("rd1_no_hold", bus.CPU_HOLD, 1'b0);
        bus.COMMIT = 1'b1;
        tick();
        chk("rd1_hold_rise", bus.CPU_HOLD, 1'b1);
        bus.COMMIT = 1'b0;
        repeat (2) tick();
        chk("rd1_memrd", bus.MEM_RD, 1'b1);
        wait_idle("rd1_idle", 20);

        // Write burst of 3 with READY gaps
        bus.DEBUG_XFER_READY = 1'b0;
        start_req(8'd3, 1'b1, 1'b0);
        push_evt(S_WR, 3, -1);
        push_evt(S_WR, 2, 5);
        push_evt(S_WR, 1, 5);
        push_hold(16);
        push_evt(S_DONE, 0, 2);
        bus.COMMIT = 1'b1;
        tick();
        bus.COMMIT = 1'b0;
        tick();
        for (int w = 0; w < 3; w++) begin
            repeat (2) tick();
            bus.DEBUG_XFER_READY = 1'b1;
            tick();
            chk("wr3_memwr", bus.MEM_WR, 1'b1);
            bus.DEBUG_XFER_READY = 1'b0;
            repeat (2) tick();
        end
        wait_idle("wr3_idle", 20);

        // 256-word read burst
        bus.DEBUG_XFER_READY = 1'b1;
        start_req(8'd0, 1'b0, 1'b0);
        chk("b256_remain", bus.DEBUG_REMAIN, 9'd256);
        for (int i = 0; i < 256; i++) begin
            push_evt(S_RD, 256 - i, (i == 0) ? -1 : 2);
            push_evt(S_LD, 256 - i, 1);
        end
        push_hold(769);
        push_evt(S_DONE, 0, 1);
        bus.COMMIT = 1'b1;
        tick();
        bus.COMMIT = 1'b0;
        wait_idle("b256_idle", 900);

        // Abort in WAIT_COMMIT, with COMMIT in the same cycle
        start_req(8'd5, 1'b0, 1'b0);
        push_evt(S_DONE, 5, -1);
        bus.DEBUG_ABORT = 1'b1;
        bus.COMMIT      = 1'b1;
        tick();
        chk("abw_hold", bus.CPU_HOLD, 1'b0);
        chk("abw_done", bus.DEBUG_DONE, 1'b1);
        bus.DEBUG_ABORT = 1'b0;
        bus.COMMIT      = 1'b0;
        tick();
        chk("abw_remain", bus.DEBUG_REMAIN, 9'd5);
        chk("abw_idle", bus.BUSY, 1'b0);

        // Abort in WAIT_RDY after the first of 4 words
        bus.DEBUG_XFER_READY = 1'b1;
        start_req(8'd4, 1'b0, 1'b1);
        push_evt(S_RD, 4, -1);
        push_evt(S_LD | S_INC, 4, 1);
        push_hold(5);
        push_evt(S_DONE, 3, 2);
        bus.COMMIT = 1'b1;
        tick();
        bus.COMMIT = 1'b0;
        repeat (3) tick();
        bus.DEBUG_XFER_READY = 1'b0;
        tick();
        chk("abr_hold", bus.CPU_HOLD, 1'b1);
        bus.DEBUG_ABORT = 1'b1;
        tick();
        chk("abr_remain", bus.DEBUG_REMAIN, 9'd3);
        chk("abr_done", bus.DEBUG_DONE, 1'b1);
        bus.DEBUG_ABORT = 1'b0;
        wait_idle("abr_idle", 10);

        // Reset during ACCESS
        bus.DEBUG_XFER_READY = 1'b1;
        start_req(8'd2, 1'b1, 1'b1);
        push_evt(S_WR, 2, -1);
        push_hold(3);
        bus.COMMIT = 1'b1;
        tick();
        bus.COMMIT = 1'b0;
        repeat (2) tick();
        chk("mrst_memwr", bus.MEM_WR, 1'b1);
        RESET = 1'b1;
        tick();
        chk("mrst_outs", all_outs(), 7'd0);
        chk("mrst_remain", bus.DEBUG_REMAIN, 9'd0);
        RESET = 1'b0;
        repeat (2) tick();
        chk("mrst_idle", all_outs(), 7'd0);

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/debug_mem_sequencer.md
# debug_mem_sequencer

Schedules debug-port memory transfers onto the shared memory bus at instruction boundaries. It waits for the CPU `COMMIT` strobe, stalls the CPU and takes the bus, then runs a burst of 1–256 single-word reads or writes. Each word is paced by a ready handshake from the debug port, and the block drives the address-increment and data-latch strobes of the debug address/data registers. It sits between the debug command decoder and the memory bus mux, alongside the debug sequencer.

## Interface
Parameters:
- none

Ports:
- `CLK`  in  1  system clock; all state changes on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `COMMIT`  in  1  one-cycle pulse at each instruction commit (nominally every 4 CLK)
- `DEBUG_REQ`  in  1  start-transfer request; sampled only in IDLE
- `DEBUG_WR`  in  1  direction, captured with REQ: 1 = write, 0 = read
- `DEBUG_AUTO_INC`  in  1  captured with REQ: pulse `DEBUG_ADDR_INC` after each word
- `DEBUG_COUNT`  in  8  captured with REQ: word count; 0 means 256
- `DEBUG_XFER_READY`  in  1  write: write data valid; read: read buffer free
- `DEBUG_ABORT`  in  1  terminate burst early
- `CPU_HOLD`  out  1  stalls CPU; also selects debug side of bus mux
- `MEM_RD`  out  1  one-cycle bus read strobe
- `MEM_WR`  out  1  one-cycle bus write strobe
- `DEBUG_DATA_LD`  out  1  one-cycle; latch bus read data into debug data register
- `DEBUG_ADDR_INC`  out  1  one-cycle; increment debug address register
- `DEBUG_DONE`  out  1  one-cycle pulse on burst end (normal or aborted)
- `BUSY`  out  1  high in every state except IDLE
- `DEBUG_REMAIN`  out  9  words still to transfer (0–256)

## Operation
- States: IDLE, WAIT_COMMIT, HOLD, WAIT_RDY, ACCESS, LATCH, RELEASE.
- All outputs are a Moore decode of the registered state. The only exception is `DEBUG_REMAIN`, which is a register.
- **IDLE:**
  - If `DEBUG_REQ` is high, capture WR, AUTO_INC and COUNT, and load REMAIN = (COUNT==0 ? 256 : COUNT).
  - Go to WAIT_COMMIT.
  - A `COMMIT` in the same cycle as the request is ignored.
- **WAIT_COMMIT:**
  - `COMMIT` → HOLD.
  - `DEBUG_ABORT` (takes priority over `COMMIT`) → RELEASE with `CPU_HOLD` never asserted.
- **HOLD:** one bus-turnaround cycle, then → WAIT_RDY.
- **WAIT_RDY:**
  - `DEBUG_ABORT` → RELEASE.
  - Otherwise `DEBUG_XFER_READY` → ACCESS.
  - Otherwise stay.
- **ACCESS:**
  - `MEM_WR` is high if WR was captured, else `MEM_RD`.
  - Always → LATCH. ABORT is ignored here.
- **LATCH:**
  - `DEBUG_DATA_LD` is high for reads only.
  - `DEBUG_ADDR_INC` is high if AUTO_INC was captured.
  - REMAIN decrements by 1.
  - If the pre-decrement REMAIN == 1 or `DEBUG_ABORT` is high → RELEASE; else → WAIT_RDY.
- **RELEASE:**
  - `DEBUG_DONE` is high and `CPU_HOLD` is low.
  - Always → IDLE.
- `CPU_HOLD` is high in HOLD, WAIT_RDY, ACCESS and LATCH only.
- `DEBUG_REQ` outside IDLE is ignored. Request inputs need not be held after capture.
- `DEBUG_REMAIN` holds its last value in IDLE until the next capture. After an abort it shows the untransferred word count.

## Timing
- **Reset:** on the first edge with `RESET` high, state = IDLE and REMAIN = 0, so every output is 0. `RESET` overrides every other input, and reset mid-burst takes effect the same edge with no DONE pulse.
- **Request:** a request captured at edge t gives WAIT_COMMIT from t+1.
- **Bus takeover:** `COMMIT` high at edge c gives HOLD (`CPU_HOLD` rises) from c+1.
- **Single word with READY held high:** HOLD, WAIT_RDY, ACCESS, LATCH, RELEASE. `CPU_HOLD` is high for exactly 4 cycles and the strobe is in the 3rd held cycle.
- **Multi-word burst with READY held high:** 3 cycles per additional word (WAIT_RDY, ACCESS, LATCH).
- **Strobe spacing:** strobes are exactly one cycle wide. There are at least 2 idle cycles between consecutive `MEM_RD`/`MEM_WR` strobes.
- **REMAIN:** changes only on the edge leaving LATCH. It is 9 bits so that 256 is representable, and it never wraps below 0.

## Test plan
1. **Reset values:** hold RESET for 2 cycles with REQ=1 and COMMIT toggling → all outputs 0, REMAIN=0, BUSY=0; after release, REQ is first honoured one cycle later.
2. **Single read:** COUNT=1, WR=0, AUTO_INC=1, READY=1, REQ pulsed 1 cycle after a COMMIT → BUSY rises next cycle. `CPU_HOLD` rises one cycle after the following COMMIT and is high 4 cycles. One MEM_RD, then DATA_LD+ADDR_INC together next cycle, then DONE; REMAIN 1→0.
3. **Write burst with READY gaps:** COUNT=3, WR=1, AUTO_INC=0, READY low for 2 cycles before each word → 3 MEM_WR pulses, each 1 cycle after READY is seen. No ADDR_INC or DATA_LD pulses; REMAIN 3→2→1→0; one DONE.
4. **256-word burst:** COUNT=0, READY=1 → REMAIN loads 256, 256 MEM_RD pulses 3 cycles apart, `CPU_HOLD` continuous for 1+3×256 cycles, DONE once.
5. **Abort before and during a burst:**
   - ABORT in WAIT_COMMIT → RELEASE next cycle with CPU_HOLD never high; REMAIN stays at the loaded value.
   - COUNT=4 with ABORT in WAIT_RDY after the first word → RELEASE next cycle; REMAIN=3.
6. **Reset mid-access:** assert RESET during ACCESS → next cycle IDLE with all outputs 0 and no DONE or LATCH strobes.
